mos6502s_memctl: RTL and testbench



---
 rtl/mos6502s_mem_pkg.sv | 18 +
 rtl/mos6502s_mem_array.sv | 25 ++
 rtl/mos6502s_memctl.sv | 204 ++++++++++++++++++++
 tb/tb_mos6502s_memctl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mos6502s_mem_pkg.sv
// Shared types for the mos6502s memory controller: FSM states, address regions
// and the wait-state counter width.
package mos6502s_mem_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_LOAD = 2'd2
  } state_t;

  typedef enum logic {
    REG_RAM = 1'b0,
    REG_ROM = 1'b1
  } region_t;

endpackage

// File: rtl/mos6502s_mem_array.sv
// Single-port synchronous array: one write or one registered read per enabled edge.
// The read register holds its value across writes and idle cycles.
module mos6502s_mem_array #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 8,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/mos6502s_memctl.sv
// RAM/ROM memory controller for the mos6502s CPU with per-region wait states,
// a RDY-style ready handshake and a bootstrap ROM load port.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// ST_IDLE | ready=1; zero-wait accesses complete here, others are latched
// ST_WAIT | ready=0; cnt counts down, latched access performed when cnt==1
// ST_LOAD | ready=0; load port owns the ROM write port
module mos6502s_memctl
  import mos6502s_mem_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int ROM_BASE = 'h8000,
  parameter int RAM_WAIT = 0,
  parameter int ROM_WAIT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rw,
  input  logic              cs,
  output logic [DATA_W-1:0] data_out,
  output logic              ready,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_we,
  output logic              rom_wr_err,
  input  logic              err_clr
);

  localparam int RAM_DEPTH = ROM_BASE;
  localparam int ROM_DEPTH = (1 << ADDR_W) - ROM_BASE;
  localparam int RAM_AW    = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam int ROM_AW    = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;

  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(ROM_BASE);
  localparam logic [CNT_W-1:0]  RAM_W = CNT_W'(RAM_WAIT);
  localparam logic [CNT_W-1:0]  ROM_W = CNT_W'(ROM_WAIT);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [ADDR_W-1:0]  lat_addr;
  logic [DATA_W-1:0]  lat_data;
  logic               lat_rw;
  region_t            lat_region;
  logic               rd_valid;
  logic               rd_rom;

  region_t            req_region;
  logic [CNT_W-1:0]   w_sel;
  logic               acc_go;
  logic [ADDR_W-1:0]  acc_addr;
  logic [DATA_W-1:0]  acc_data;
  logic               acc_rw;
  region_t            acc_region;
  logic [ADDR_W-1:0]  acc_off;
  logic [ADDR_W-1:0]  load_off;
  logic [ADDR_W-1:0]  rom_addr_full;
  logic               ram_en;
  logic               ram_we;
  logic               rom_en;
  logic               rom_we;
  logic [DATA_W-1:0]  rom_wdata;
  logic               rom_set;
  logic [DATA_W-1:0]  ram_q;
  logic [DATA_W-1:0]  rom_q;

  assign req_region = (addr >= BASE) ? REG_ROM : REG_RAM;
  assign w_sel      = (req_region == REG_ROM) ? ROM_W : RAM_W;

  // Zero-wait accesses use the live bus; waited accesses use the latched copy.
  always_comb begin
    acc_addr   = lat_addr;
    acc_data   = lat_data;
    acc_rw     = lat_rw;
    acc_region = lat_region;
    acc_go     = 1'b0;
    if (state == ST_IDLE) begin
      acc_addr   = addr;
      acc_data   = data_in;
      acc_rw     = rw;
      acc_region = req_region;
      acc_go     = rst_n && cs && !load_en && (w_sel == '0);
    end else if (state == ST_WAIT) begin
      acc_go = rst_n && (cnt == CNT_W'(1));
    end
  end

  assign acc_off  = acc_addr - BASE;
  assign load_off = load_addr - BASE;

  always_comb begin
    ram_en        = acc_go && (acc_region == REG_RAM);
    ram_we        = !acc_rw;
    rom_set       = acc_go && (acc_region == REG_ROM) && !acc_rw;
    rom_en        = acc_go && (acc_region == REG_ROM) && acc_rw;
    rom_we        = 1'b0;
    rom_addr_full = acc_off;
    rom_wdata     = load_data;
    if (state == ST_LOAD) begin
      rom_en        = rst_n && load_we && (load_addr >= BASE);
      rom_we        = 1'b1;
      rom_addr_full = load_off;
    end
  end

  mos6502s_mem_array #(
    .DEPTH  (RAM_DEPTH),
    .DATA_W (DATA_W),
    .AW     (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (acc_addr[RAM_AW-1:0]),
    .wdata (acc_data),
    .rdata (ram_q)
  );

  mos6502s_mem_array #(
    .DEPTH  (ROM_DEPTH),
    .DATA_W (DATA_W),
    .AW     (ROM_AW)
  ) u_rom (
    .clk   (clk),
    .en    (rom_en),
    .we    (rom_we),
    .addr  (rom_addr_full[ROM_AW-1:0]),
    .wdata (rom_wdata),
    .rdata (rom_q)
  );

  // rd_valid masks stale array read registers so data_out is zero after reset.
  assign data_out = !rd_valid ? '0 : (rd_rom ? rom_q : ram_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      ready      <= 1'b1;
      rom_wr_err <= 1'b0;
      rd_valid   <= 1'b0;
      rd_rom     <= 1'b0;
      lat_addr   <= '0;
      lat_data   <= '0;
      lat_rw     <= 1'b1;
      lat_region <= REG_RAM;
    end else begin
      if (rom_set)      rom_wr_err <= 1'b1;
      else if (err_clr) rom_wr_err <= 1'b0;

      if (acc_go && acc_rw) begin
        rd_valid <= 1'b1;
        rd_rom   <= (acc_region == REG_ROM);
      end

      case (state)
        ST_IDLE: begin
          if (load_en) begin
            state <= ST_LOAD;
            ready <= 1'b0;
          end else if (cs) begin
            lat_addr   <= addr;
            lat_data   <= data_in;
            lat_rw     <= rw;
            lat_region <= req_region;
            if (w_sel != '0) begin
              cnt   <= w_sel;
              state <= ST_WAIT;
              ready <= 1'b0;
            end
          end
        end
        ST_WAIT: begin
          if (cnt <= CNT_W'(1)) begin
            cnt <= '0;
            if (load_en) begin
              state <= ST_LOAD;
            end else begin
              state <= ST_IDLE;
              ready <= 1'b1;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_LOAD: begin
          if (!load_en) begin
            state <= ST_IDLE;
            ready <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mos6502s_memctl.sv
// Directed bench: dut_a uses the 32K/32K split (RAM 0 waits, ROM 2 waits),
// dut_b uses ROM_BASE='hC000 (RAM 3 waits, ROM 1 wait).
module tb_mos6502s_memctl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] addr = '0;
  logic [7:0]  data_in = '0;
  logic        rw = 1'b1;
  logic        cs_a = 1'b0, cs_b = 1'b0;
  logic        load_en_a = 1'b0, load_en_b = 1'b0;
  logic [15:0] load_addr = '0;
  logic [7:0]  load_data = '0;
  logic        load_we = 1'b0;
  logic        err_clr = 1'b0;
  logic [7:0]  data_out_a, data_out_b;
  logic        ready_a, ready_b, rom_wr_err_a, rom_wr_err_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mos6502s_memctl #(.ADDR_W(16), .DATA_W(8), .ROM_BASE('h8000), .RAM_WAIT(0), .ROM_WAIT(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .addr(addr), .data_in(data_in), .rw(rw), .cs(cs_a),
    .data_out(data_out_a), .ready(ready_a), .load_en(load_en_a), .load_addr(load_addr),
    .load_data(load_data), .load_we(load_we), .rom_wr_err(rom_wr_err_a), .err_clr(err_clr));

  mos6502s_memctl #(.ADDR_W(16), .DATA_W(8), .ROM_BASE('hC000), .RAM_WAIT(3), .ROM_WAIT(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .addr(addr), .data_in(data_in), .rw(rw), .cs(cs_b),
    .data_out(data_out_b), .ready(ready_b), .load_en(load_en_b), .load_addr(load_addr),
    .load_data(load_data), .load_we(load_we), .rom_wr_err(rom_wr_err_b), .err_clr(err_clr));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request and returns after the cycle where ready is back to 1;
  // lows is the number of ready-low cycles seen (40 means the wait expired).
  task automatic access(input bit on_b, input logic [15:0] a, input logic rd,
                        input logic [7:0] d, output int lows);
    addr = a; rw = rd; data_in = d;
    if (on_b) cs_b = 1'b1; else cs_a = 1'b1;
    tick();
    cs_a = 1'b0; cs_b = 1'b0; rw = 1'b1;
    lows = 0;
    for (int i = 0; i < 40; i++) begin
      if ((on_b ? ready_b : ready_a) === 1'b1) break;
      lows++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++; if (data_out_a !== 8'h00) begin errors++; $display("FAIL reset_data_a got %h exp 00", data_out_a); end
    checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL reset_ready_a got %b exp 1", ready_a); end
    checks++; if (rom_wr_err_a !== 1'b0) begin errors++; $display("FAIL reset_err_a got %b exp 0", rom_wr_err_a); end
    checks++; if (data_out_b !== 8'h00) begin errors++; $display("FAIL reset_data_b got %h exp 00", data_out_b); end
    checks++; if (ready_b !== 1'b1) begin errors++; $display("FAIL reset_ready_b got %b exp 1", ready_b); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_ram_rw();
    int lows;
    access(0, 16'h0010, 1'b0, 8'h5A, lows);
    checks++; if (lows !== 0) begin errors++; $display("FAIL ram_wr_lows got %0d exp 0", lows); end
    checks++; if (data_out_a !== 8'h00) begin errors++; $display("FAIL ram_wr_data_unchanged got %h exp 00", data_out_a); end
    access(0, 16'h0010, 1'b1, 8'h00, lows);
    checks++; if (lows !== 0) begin errors++; $display("FAIL ram_rd_lows got %0d exp 0", lows); end
    checks++; if (data_out_a !== 8'h5A) begin errors++; $display("FAIL ram_rd_0010 got %h exp 5a", data_out_a); end
    access(0, 16'h0020, 1'b0, 8'h3C, lows);
    access(0, 16'h0020, 1'b1, 8'h00, lows);
    checks++; if (data_out_a !== 8'h3C) begin errors++; $display("FAIL ram_rd_0020 got %h exp 3c", data_out_a); end
    tick(); tick();
    checks++; if (data_out_a !== 8'h3C) begin errors++; $display("FAIL ram_hold_idle got %h exp 3c", data_out_a); end
  endtask

  task automatic test_back_to_back();
    addr = 16'h0010; rw = 1'b1; cs_a = 1'b1;
    tick();
    checks++; if (data_out_a !== 8'h5A) begin errors++; $display("FAIL b2b_first got %h exp 5a", data_out_a); end
    addr = 16'h0020;
    tick();
    checks++; if (data_out_a !== 8'h3C) begin errors++; $display("FAIL b2b_second got %h exp 3c", data_out_a); end
    checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b exp 1", ready_a); end
    cs_a = 1'b0;
    tick();
  endtask

  task automatic test_rom_load();
    int lows;
    load_en_a = 1'b1;
    tick();
    checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL load_ready_low got %b exp 0", ready_a); end
    load_we = 1'b1; load_addr = 16'h8000; load_data = 8'hA9;
    tick();
    load_addr = 16'hFFFC; load_data = 8'h00;
    tick();
    load_addr = 16'h0010; load_data = 8'h77;
    tick();
    load_we = 1'b0; load_en_a = 1'b0;
    tick();
    checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL load_exit_ready got %b exp 1", ready_a); end
    access(0, 16'hFFFC, 1'b1, 8'h00, lows);
    checks++; if (lows !== 2) begin errors++; $display("FAIL rom_rd_lows got %0d exp 2", lows); end
    checks++; if (data_out_a !== 8'h00) begin errors++; $display("FAIL rom_rd_fffc got %h exp 00", data_out_a); end
    access(0, 16'h0010, 1'b1, 8'h00, lows);
    checks++; if (data_out_a !== 8'h5A) begin errors++; $display("FAIL load_low_ignored got %h exp 5a", data_out_a); end
    access(0, 16'h8000, 1'b1, 8'h00, lows);
    checks++; if (data_out_a !== 8'hA9) begin errors++; $display("FAIL rom_rd_8000 got %h exp a9", data_out_a); end
    access(0, 16'hFFFC, 1'b1, 8'h00, lows);
    checks++; if (lows !== 2 || data_out_a !== 8'h00) begin errors++; $display("FAIL rom_b2b got lows %0d data %h exp 2 00", lows, data_out_a); end
  endtask

  task automatic test_rom_protect();
    int lows;
    access(0, 16'h8000, 1'b1, 8'h00, lows);
    addr = 16'h8000; rw = 1'b0; data_in = 8'hFF; cs_a = 1'b1;
    tick();
    cs_a = 1'b0; rw = 1'b1;
    checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL romwr_ready got %b exp 0", ready_a); end
    tick(); tick();
    checks++; if (rom_wr_err_a !== 1'b1) begin errors++; $display("FAIL romwr_err_set got %b exp 1", rom_wr_err_a); end
    checks++; if (data_out_a !== 8'hA9) begin errors++; $display("FAIL romwr_data_unchanged got %h exp a9", data_out_a); end
    access(0, 16'h0010, 1'b1, 8'h00, lows);
    access(0, 16'h8000, 1'b1, 8'h00, lows);
    checks++; if (data_out_a !== 8'hA9) begin errors++; $display("FAIL rom_protected got %h exp a9", data_out_a); end
    addr = 16'h8000; rw = 1'b0; data_in = 8'hFF; cs_a = 1'b1;
    tick();
    cs_a = 1'b0; rw = 1'b1;
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if (rom_wr_err_a !== 1'b1) begin errors++; $display("FAIL err_set_wins got %b exp 1", rom_wr_err_a); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if (rom_wr_err_a !== 1'b0) begin errors++; $display("FAIL err_clr got %b exp 0", rom_wr_err_a); end
  endtask

  task automatic test_load_during_wait();
    int lows;
    access(0, 16'h0010, 1'b1, 8'h00, lows);
    addr = 16'h8000; rw = 1'b1; cs_a = 1'b1;
    tick();
    cs_a = 1'b0; load_en_a = 1'b1;
    tick(); tick();
    checks++; if (data_out_a !== 8'hA9) begin errors++; $display("FAIL ldwait_data got %h exp a9", data_out_a); end
    checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL ldwait_ready got %b exp 0", ready_a); end
    tick();
    checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL ldwait_in_load got %b exp 0", ready_a); end
    load_en_a = 1'b0;
    tick();
    checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL ldwait_exit got %b exp 1", ready_a); end
  endtask

  task automatic test_reset_mid_wait();
    int lows;
    access(1, 16'h0100, 1'b0, 8'h11, lows);
    checks++; if (lows !== 3) begin errors++; $display("FAIL b_ramwr_lows got %0d exp 3", lows); end
    access(1, 16'h0100, 1'b1, 8'h00, lows);
    checks++; if (data_out_b !== 8'h11) begin errors++; $display("FAIL b_ram_rd got %h exp 11", data_out_b); end
    addr = 16'h0100; rw = 1'b0; data_in = 8'hEE; cs_b = 1'b1;
    tick();
    cs_b = 1'b0; rw = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if (ready_b !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got %b exp 1", ready_b); end
    checks++; if (data_out_b !== 8'h00) begin errors++; $display("FAIL rst_mid_data got %h exp 00", data_out_b); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    access(1, 16'h0100, 1'b1, 8'h00, lows);
    checks++; if (data_out_b !== 8'h11) begin errors++; $display("FAIL rst_mid_no_write got %h exp 11", data_out_b); end
  endtask

  task automatic test_base_c000();
    int lows;
    access(1, 16'h1000, 1'b0, 8'h55, lows);
    access(1, 16'hBFFF, 1'b0, 8'h24, lows);
    checks++; if (rom_wr_err_b !== 1'b0) begin errors++; $display("FAIL bfff_is_ram_err got %b exp 0", rom_wr_err_b); end
    load_en_b = 1'b1;
    tick();
    load_we = 1'b1; load_addr = 16'hC000; load_data = 8'h42;
    tick();
    load_addr = 16'h1000; load_data = 8'h99;
    tick();
    load_we = 1'b0; load_en_b = 1'b0;
    tick();
    access(1, 16'hBFFF, 1'b1, 8'h00, lows);
    checks++; if (lows !== 3 || data_out_b !== 8'h24) begin errors++; $display("FAIL rd_bfff got lows %0d data %h exp 3 24", lows, data_out_b); end
    access(1, 16'hC000, 1'b1, 8'h00, lows);
    checks++; if (lows !== 1 || data_out_b !== 8'h42) begin errors++; $display("FAIL rd_c000 got lows %0d data %h exp 1 42", lows, data_out_b); end
    access(1, 16'h1000, 1'b1, 8'h00, lows);
    checks++; if (data_out_b !== 8'h55) begin errors++; $display("FAIL load_1000_ignored got %h exp 55", data_out_b); end
    access(1, 16'hC000, 1'b0, 8'h00, lows);
    checks++; if (rom_wr_err_b !== 1'b1) begin errors++; $display("FAIL c000_is_rom_err got %b exp 1", rom_wr_err_b); end
  endtask

  initial begin
    test_reset();
    test_ram_rw();
    test_back_to_back();
    test_rom_load();
    test_rom_protect();
    test_load_during_wait();
    test_reset_mid_wait();
    test_base_c000();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
